// File: rtl/tlc_actuated_controller.sv
// Sensor-actuated two-road traffic light controller.
// Four-phase sequence (NS green/yellow, EW green/yellow) separated by all-red
// clearance, plus an optional pedestrian walk phase and a maintenance flash mode.
// Green phases gap out on opposing demand once the minimum green has elapsed.
// They max out at GREEN_MAX while their own road still has a car waiting.
// The phase register doubles as the debug view of the state machine.
// Lamp outputs are registered. They are decoded from the next phase, so each
// lamp always matches the phase reported on the same cycle.
module tlc_actuated_controller #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int PED_T     = 6,
  parameter int FLASH_T   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] light_north_south,
  output logic [2:0] light_east_west,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G    = 3'd0,
    NS_Y    = 3'd1,
    ALL_RED = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    PED     = 3'd5,
    FLASH   = 3'd6,
    UNUSED  = 3'd7
  } phase_e;

  // Lamp encodings: [Red, Yellow, Green]
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Direction served by the next green after clearance
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] PED_M1  = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] FLS_M1  = CNT_W'(FLASH_T - 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             next_dir_q, next_dir_d;
  logic             ns_req_q, ns_req_d;
  logic             ew_req_q, ew_req_d;
  logic             ped_pend_q, ped_pend_d;
  logic             flash_on_q, flash_on_d;
  logic [2:0]       lns_q, lns_d;
  logic [2:0]       lew_q, lew_d;
  logic             walk_q, walk_d;

  // Next-state logic: request latches, phase sequencing and the phase timer
  always_comb begin
    phase_d    = phase_q;
    timer_d    = timer_q + ONE;
    next_dir_d = next_dir_q;
    flash_on_d = flash_on_q;
    // A road's request is consumed while that road is green; a walk request
    // is consumed by the walk phase. Everything else keeps accumulating.
    ns_req_d   = (phase_q == NS_G) ? 1'b0 : (ns_req_q | car_ns);
    ew_req_d   = (phase_q == EW_G) ? 1'b0 : (ew_req_q | car_ew);
    ped_pend_d = (phase_q == PED)  ? 1'b0 : (ped_pend_q | ped_req);

    if (flash_mode) begin
      // Flash overrides everything; inside flash the timer paces the blink
      if (phase_q != FLASH) begin
        phase_d    = FLASH;
        timer_d    = '0;
        flash_on_d = 1'b1;
      end else if (timer_q == FLS_M1) begin
        timer_d    = '0;
        flash_on_d = ~flash_on_q;
      end
    end else begin
      case (phase_q)
        NS_G: begin
          if ((timer_q >= GMIN_M1) && (ew_req_q | ped_pend_q) &&
              (!car_ns || (timer_q == GMAX_M1))) begin
            phase_d = NS_Y;
            timer_d = '0;
          end else if (timer_q == GMAX_M1) begin
            timer_d = timer_q;
          end
        end
        EW_G: begin
          if ((timer_q >= GMIN_M1) && (ns_req_q | ped_pend_q) &&
              (!car_ew || (timer_q == GMAX_M1))) begin
            phase_d = EW_Y;
            timer_d = '0;
          end else if (timer_q == GMAX_M1) begin
            timer_d = timer_q;
          end
        end
        NS_Y: begin
          if (timer_q == YEL_M1) begin
            phase_d    = ALL_RED;
            timer_d    = '0;
            next_dir_d = DIR_EW;
          end
        end
        EW_Y: begin
          if (timer_q == YEL_M1) begin
            phase_d    = ALL_RED;
            timer_d    = '0;
            next_dir_d = DIR_NS;
          end
        end
        ALL_RED: begin
          if (timer_q == AR_M1) begin
            timer_d = '0;
            if (ped_pend_q)
              phase_d = PED;
            else if (next_dir_q == DIR_EW)
              phase_d = EW_G;
            else
              phase_d = NS_G;
          end
        end
        PED: begin
          // Walk ends straight into the pending green; the walk phase is
          // already all-red for vehicles so no further clearance is needed.
          if (timer_q == PED_M1) begin
            timer_d = '0;
            phase_d = (next_dir_q == DIR_EW) ? EW_G : NS_G;
          end
        end
        FLASH: begin
          // Leaving maintenance always restarts from a clean NS-first clearance
          phase_d    = ALL_RED;
          timer_d    = '0;
          next_dir_d = DIR_NS;
        end
        default: begin
          phase_d = ALL_RED;
          timer_d = '0;
        end
      endcase
    end
  end

  // Lamp decode of the next phase, registered alongside it
  always_comb begin
    lns_d  = LAMP_R;
    lew_d  = LAMP_R;
    walk_d = 1'b0;
    case (phase_d)
      NS_G:    lns_d = LAMP_G;
      NS_Y:    lns_d = LAMP_Y;
      EW_G:    lew_d = LAMP_G;
      EW_Y:    lew_d = LAMP_Y;
      PED:     walk_d = 1'b1;
      FLASH: begin
        lns_d = flash_on_d ? LAMP_Y : LAMP_OFF;
        lew_d = flash_on_d ? LAMP_R : LAMP_OFF;
      end
      default: begin
        lns_d = LAMP_R;
        lew_d = LAMP_R;
      end
    endcase
  end

  // State and output registers with asynchronous reset to all-red clearance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= ALL_RED;
      timer_q    <= '0;
      next_dir_q <= DIR_NS;
      ns_req_q   <= 1'b0;
      ew_req_q   <= 1'b0;
      ped_pend_q <= 1'b0;
      flash_on_q <= 1'b1;
      lns_q      <= LAMP_R;
      lew_q      <= LAMP_R;
      walk_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      next_dir_q <= next_dir_d;
      ns_req_q   <= ns_req_d;
      ew_req_q   <= ew_req_d;
      ped_pend_q <= ped_pend_d;
      flash_on_q <= flash_on_d;
      lns_q      <= lns_d;
      lew_q      <= lew_d;
      walk_q     <= walk_d;
    end
  end

  assign light_north_south = lns_q;
  assign light_east_west   = lew_q;
  assign walk              = walk_q;
  assign phase             = phase_q;

endmodule

// File: tb/tb_tlc_actuated_controller.sv
// Bench for tlc_actuated_controller. Each scenario queues the expected
// per-cycle {phase, NS lamp, EW lamp, walk} observations as it drives inputs.
// It then pops and compares one entry per clock, sampled 1 ns after the rising edge.
module tb_tlc_actuated_controller;

  localparam int W = 10;

  localparam logic [2:0] P_NS_G  = 3'd0;
  localparam logic [2:0] P_NS_Y  = 3'd1;
  localparam logic [2:0] P_AR    = 3'd2;
  localparam logic [2:0] P_EW_G  = 3'd3;
  localparam logic [2:0] P_EW_Y  = 3'd4;
  localparam logic [2:0] P_PED   = 3'd5;
  localparam logic [2:0] P_FLASH = 3'd6;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic       clk;
  logic       reset;
  logic       car_ns;
  logic       car_ew;
  logic       ped_req;
  logic       flash_mode;
  logic [2:0] light_north_south;
  logic [2:0] light_east_west;
  logic       walk;
  logic [2:0] phase;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  tlc_actuated_controller dut (
    .clk               (clk),
    .reset             (reset),
    .car_ns            (car_ns),
    .car_ew            (car_ew),
    .ped_req           (ped_req),
    .flash_mode        (flash_mode),
    .light_north_south (light_north_south),
    .light_east_west   (light_east_west),
    .walk              (walk),
    .phase             (phase)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] observed();
    return {phase, light_north_south, light_east_west, walk};
  endfunction

  // Queue n cycles of one expected observation
  task automatic expect_run(input logic [2:0] ph, input logic [2:0] ns,
                            input logic [2:0] ew, input logic wk, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ph, ns, ew, wk});
  endtask

  // Driver: reset, release, and step to the first cycle of the initial NS green
  task automatic do_reset();
    car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [W-1:0] e, o;
    int n;
    car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed() !== {P_AR, R, R, 1'b0}) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", observed(), {P_AR, R, R, 1'b0});
    end
    reset = 1'b0;
    checks++;
    if (observed() !== {P_AR, R, R, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", observed(), {P_AR, R, R, 1'b0});
    end
    n = $urandom_range(25, 40);
    expect_run(P_AR, R, R, 1'b0, 1);
    expect_run(P_NS_G, G, R, 1'b0, n);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_reset got=%b exp=%b", o, e); end
    end
  endtask

  task automatic test_gap_out();
    logic [W-1:0] e, o;
    do_reset();
    expect_run(P_NS_G, G, R, 1'b0, 1);
    @(posedge clk); #1;
    car_ew = 1'b1;
    expect_run(P_NS_G, G, R, 1'b0, 1);
    @(posedge clk); #1;
    car_ew = 1'b0;
    expect_run(P_NS_G, G, R, 1'b0, 5);
    expect_run(P_NS_Y, Y, R, 1'b0, 3);
    expect_run(P_AR, R, R, 1'b0, 2);
    expect_run(P_EW_G, R, G, 1'b0, $urandom_range(10, 25));
    // the first two cycles were stepped above; compare them now
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (e !== {P_NS_G, G, R, 1'b0}) begin failures++; $display("FAIL test_gap_out_q got=%b exp=%b", e, {P_NS_G, G, R, 1'b0}); end
    end
    checks++;
    if (observed() !== {P_NS_G, G, R, 1'b0}) begin
      failures++;
      $display("FAIL test_gap_out_t2 got=%b exp=%b", observed(), {P_NS_G, G, R, 1'b0});
    end
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_gap_out got=%b exp=%b", o, e); end
    end
  endtask

  task automatic test_max_out();
    logic [W-1:0] e, o;
    do_reset();
    car_ns = 1'b1; car_ew = 1'b1;
    expect_run(P_NS_G, G, R, 1'b0, 19);
    for (int k = 0; k < 2; k++) begin
      expect_run(P_NS_Y, Y, R, 1'b0, 3);
      expect_run(P_AR, R, R, 1'b0, 2);
      expect_run(P_EW_G, R, G, 1'b0, 20);
      expect_run(P_EW_Y, R, Y, 1'b0, 3);
      expect_run(P_AR, R, R, 1'b0, 2);
      expect_run(P_NS_G, G, R, 1'b0, 20);
    end
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_max_out got=%b exp=%b", o, e); end
    end
    car_ns = 1'b0; car_ew = 1'b0;
  endtask

  task automatic test_ped();
    logic [W-1:0] e, o;
    do_reset();
    ped_req = 1'b1;
    @(posedge clk); #1;
    ped_req = 1'b0;
    checks++;
    if (observed() !== {P_NS_G, G, R, 1'b0}) begin
      failures++;
      $display("FAIL test_ped_t1 got=%b exp=%b", observed(), {P_NS_G, G, R, 1'b0});
    end
    expect_run(P_NS_G, G, R, 1'b0, 6);
    expect_run(P_NS_Y, Y, R, 1'b0, 3);
    expect_run(P_AR, R, R, 1'b0, 2);
    expect_run(P_PED, R, R, 1'b1, 6);
    expect_run(P_EW_G, R, G, 1'b0, $urandom_range(10, 25));
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_ped got=%b exp=%b", o, e); end
    end
  endtask

  task automatic test_flash();
    logic [W-1:0] e, o;
    do_reset();
    car_ew = 1'b1;
    @(posedge clk); #1;
    car_ew = 1'b0;
    expect_run(P_NS_G, G, R, 1'b0, 6);
    expect_run(P_NS_Y, Y, R, 1'b0, 3);
    expect_run(P_AR, R, R, 1'b0, 2);
    expect_run(P_EW_G, R, G, 1'b0, 5);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_flash_lead got=%b exp=%b", o, e); end
    end
    flash_mode = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (observed() !== {P_FLASH, Y, R, 1'b0}) begin
      failures++;
      $display("FAIL test_flash_entry got=%b exp=%b", observed(), {P_FLASH, Y, R, 1'b0});
    end
    // an EW car arriving during flash must survive it
    car_ew = 1'b1;
    @(posedge clk); #1;
    car_ew = 1'b0;
    checks++;
    if (observed() !== {P_FLASH, Y, R, 1'b0}) begin
      failures++;
      $display("FAIL test_flash_on got=%b exp=%b", observed(), {P_FLASH, Y, R, 1'b0});
    end
    expect_run(P_FLASH, Y, R, 1'b0, 2);
    expect_run(P_FLASH, OFF, OFF, 1'b0, 4);
    expect_run(P_FLASH, Y, R, 1'b0, 4);
    expect_run(P_FLASH, OFF, OFF, 1'b0, 2);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_flash_blink got=%b exp=%b", o, e); end
    end
    flash_mode = 1'b0;
    expect_run(P_AR, R, R, 1'b0, 2);
    expect_run(P_NS_G, G, R, 1'b0, 8);
    expect_run(P_NS_Y, Y, R, 1'b0, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_flash_exit got=%b exp=%b", o, e); end
    end
  endtask

  task automatic test_reset_mid_ped();
    logic [W-1:0] e, o;
    do_reset();
    ped_req = 1'b1;
    @(posedge clk); #1;
    ped_req = 1'b0;
    expect_run(P_NS_G, G, R, 1'b0, 6);
    expect_run(P_NS_Y, Y, R, 1'b0, 3);
    expect_run(P_AR, R, R, 1'b0, 2);
    expect_run(P_PED, R, R, 1'b1, 2);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_reset_mid_ped_lead got=%b exp=%b", o, e); end
    end
    // latch an EW request that reset must discard
    car_ew = 1'b1;
    @(posedge clk); #1;
    car_ew = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== {P_AR, R, R, 1'b0}) begin
      failures++;
      $display("FAIL test_reset_async got=%b exp=%b", observed(), {P_AR, R, R, 1'b0});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    expect_run(P_AR, R, R, 1'b0, 1);
    expect_run(P_NS_G, G, R, 1'b0, 20);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed();
      checks++;
      if (o !== e) begin failures++; $display("FAIL test_reset_mid_ped got=%b exp=%b", o, e); end
    end
  endtask

  // Scenario sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
    test_reset();
    test_gap_out();
    test_max_out();
    test_ped();
    test_flash();
    test_reset_mid_ped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
